mem_arbiter: RTL and testbench

Two-requester arbiter sharing one single-beat memory port between the fetch-stage instruction bus and the memory-stage data bus. It sits between `core` and the memory system. It grants one transaction at a time, favours the data side because it carries the older instruction, and bounds instruction-side starvation with a counter. Both requesters keep their existing valid/addr_ok/data_ok protocol unchanged.

---
 rtl/mem_arbiter_pkg.sv | 60 ++++++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared bus types and arbiter state encoding for the instruction/data/memory ports.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a; each bus uses its own valid/addr_ok/data_ok handshake.
package mem_arbiter_pkg;

    // Instruction fetches are always 32-bit reads.
    localparam logic [2:0] IBUS_SIZE = 3'b010;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } mem_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } mem_resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    // Pick the 32-bit word of a 64-bit beat addressed by addr[2].
    function automatic logic [31:0] word_select(input logic [63:0] beat, input logic upper);
        return upper ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Purpose: share one single-beat memory port between the instruction and data buses, data first, bounded instruction starvation.
// Latency: grant visible one cycle after a request is seen in IDLE; responses pass through combinationally.
// Backpressure: one transaction in flight; the loser simply holds valid until it is granted and sees data_ok.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output mem_req_t   mreq,
    input  mem_resp_t  mresp
);

    localparam int             CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             gnt_i;
    logic             gnt_d;

    // State and starvation counter registers; reset abandons any grant in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            starve_cnt <= '0;
        end else begin
            state_q    <= state_d;
            starve_cnt <= starve_cnt_d;
        end
    end

    // Priority selection: data wins unless the instruction side has waited STARVE_MAX data grants.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt;
        unique case (state_q)
            ARB_IDLE: begin
                if (dreq.valid && !(ireq.valid && (starve_cnt == CNT_MAX))) begin
                    state_d = ARB_GRANT_D;
                    // Only count data grants that actually made an instruction fetch wait.
                    if (ireq.valid && (starve_cnt != CNT_MAX)) begin
                        starve_cnt_d = starve_cnt + CNT_W'(1);
                    end
                end else if (ireq.valid) begin
                    state_d      = ARB_GRANT_I;
                    starve_cnt_d = '0;
                end
            end
            ARB_GRANT_I, ARB_GRANT_D: begin
                // A data_ok seen in IDLE falls through the default hold above and is ignored.
                if (mresp.data_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Grants are masked during reset so an aborted transaction can never leak a response.
    assign gnt_i = (state_q == ARB_GRANT_I) && !reset;
    assign gnt_d = (state_q == ARB_GRANT_D) && !reset;

    // Memory request mux and response routing; the idle/non-granted side sees all zeros.
    always_comb begin
        mreq  = '0;
        iresp = '0;
        dresp = '0;
        if (gnt_i) begin
            mreq.valid     = 1'b1;
            mreq.is_write  = 1'b0;
            mreq.addr      = ireq.addr;
            mreq.size      = IBUS_SIZE;
            mreq.strobe    = '0;
            mreq.data      = '0;
            iresp.addr_ok  = mresp.addr_ok;
            iresp.data_ok  = mresp.data_ok;
            iresp.data     = word_select(mresp.data, ireq.addr[2]);
        end else if (gnt_d) begin
            mreq.valid     = 1'b1;
            mreq.is_write  = (dreq.strobe != 8'h00);
            mreq.addr      = dreq.addr;
            mreq.size      = dreq.size;
            mreq.strobe    = dreq.strobe;
            mreq.data      = dreq.data;
            dresp.addr_ok  = mresp.addr_ok;
            dresp.data_ok  = mresp.data_ok;
            dresp.data     = mresp.data;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against an ownership model.
// Latency: model predicts grant one cycle after a request is seen with the port free.
// Backpressure: bench requesters hold fields until data_ok; the bench memory answers after a random delay.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int SMAX = 4;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    mem_req_t   mreq;
    mem_resp_t  mresp;

    mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .mreq  (mreq),
        .mresp (mresp)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the memory port (0 free, 1 instruction, 2 data)
    // and how many data grants in a row were made while a fetch was waiting.
    int owner    = 0;
    int d_streak = 0;

    mem_req_t   exp_mreq;
    ibus_resp_t exp_iresp;
    dbus_resp_t exp_dresp;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Let inputs settle, then compare every DUT output with what the owner implies.
    task automatic settle(input string tag);
        #1;
        exp_mreq  = '0;
        exp_iresp = '0;
        exp_dresp = '0;
        if (!reset && owner == 1) begin
            exp_mreq.valid    = 1'b1;
            exp_mreq.addr     = ireq.addr;
            exp_mreq.size     = 3'd2;
            exp_iresp.addr_ok = mresp.addr_ok;
            exp_iresp.data_ok = mresp.data_ok;
            exp_iresp.data    = ireq.addr[2] ? mresp.data[63:32] : mresp.data[31:0];
        end else if (!reset && owner == 2) begin
            exp_mreq.valid    = 1'b1;
            exp_mreq.is_write = (dreq.strobe != 8'h00);
            exp_mreq.addr     = dreq.addr;
            exp_mreq.size     = dreq.size;
            exp_mreq.strobe   = dreq.strobe;
            exp_mreq.data     = dreq.data;
            exp_dresp.addr_ok = mresp.addr_ok;
            exp_dresp.data_ok = mresp.data_ok;
            exp_dresp.data    = mresp.data;
        end
        check_eq({tag, ".mreq"},  256'(mreq),  256'(exp_mreq));
        check_eq({tag, ".iresp"}, 256'(iresp), 256'(exp_iresp));
        check_eq({tag, ".dresp"}, 256'(dresp), 256'(exp_dresp));
    endtask

    // Clock edge: update ownership from the inputs seen this cycle, then move to the next drive point.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            owner    = 0;
            d_streak = 0;
        end else if (owner == 0) begin
            if (dreq.valid && ireq.valid) begin
                if (d_streak >= SMAX) begin
                    owner    = 1;
                    d_streak = 0;
                end else begin
                    owner    = 2;
                    d_streak = d_streak + 1;
                end
            end else if (dreq.valid) begin
                owner = 2;
            end else if (ireq.valid) begin
                owner    = 1;
                d_streak = 0;
            end
        end else if (mresp.data_ok) begin
            owner = 0;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ireq  = '0;
        dreq  = '0;
        mresp = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        settle("rst");
        advance();
        reset = 1'b0;
    endtask

    initial begin
        int grants[$];
        logic prev_vld;
        logic i_done;
        logic d_done;

        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        settle("reset0");
        advance();
        settle("reset1");
        check_eq("reset.mreq_zero", 256'(mreq), 256'(0));
        advance();
        reset = 1'b0;

        // Instruction-only fetch, upper word selected by addr[2].
        ireq.valid = 1'b1;
        ireq.addr  = 64'h0000_0000_8000_0004;
        settle("fetch.t0");
        check_eq("fetch.t0.mvalid", 256'(mreq.valid), 256'(0));
        advance();
        settle("fetch.t1");
        check_eq("fetch.t1.mvalid", 256'(mreq.valid), 256'(1));
        check_eq("fetch.t1.size", 256'(mreq.size), 256'(2));
        check_eq("fetch.t1.strobe", 256'(mreq.strobe), 256'(0));
        check_eq("fetch.t1.is_write", 256'(mreq.is_write), 256'(0));
        advance();
        settle("fetch.t2");
        advance();
        mresp.data_ok = 1'b1;
        mresp.data    = 64'h1122_3344_5566_7788;
        settle("fetch.t3");
        check_eq("fetch.t3.data_ok", 256'(iresp.data_ok), 256'(1));
        check_eq("fetch.t3.data", 256'(iresp.data), 256'(32'h1122_3344));
        advance();
        clear_inputs();
        settle("fetch.t4");
        check_eq("fetch.t4.data_ok", 256'(iresp.data_ok), 256'(0));
        advance();

        // Simultaneous requests: data first, fetch at the IDLE after.
        do_reset();
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h0000_0000_0000_1000;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_0000_2008;
        dreq.size   = 3'd3;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD_BEEF_0BAD_F00D;
        settle("sim.t0");
        advance();
        settle("sim.t1");
        check_eq("sim.t1.is_write", 256'(mreq.is_write), 256'(1));
        check_eq("sim.t1.data", 256'(mreq.data), 256'(64'hDEAD_BEEF_0BAD_F00D));
        advance();
        mresp.data_ok = 1'b1;
        settle("sim.t2");
        check_eq("sim.t2.d_ok", 256'(dresp.data_ok), 256'(1));
        advance();
        mresp.data_ok = 1'b0;
        dreq.valid    = 1'b0;
        settle("sim.t3");
        check_eq("sim.t3.mvalid", 256'(mreq.valid), 256'(0));
        advance();
        settle("sim.t4");
        check_eq("sim.t4.mvalid", 256'(mreq.valid), 256'(1));
        check_eq("sim.t4.addr", 256'(mreq.addr), 256'(64'h1000));
        advance();

        // Isolation: data side stays silent while the fetch owns the port.
        do_reset();
        ireq.valid = 1'b1;
        ireq.addr  = 64'h0000_0000_0000_0040;
        settle("iso.t0");
        advance();
        dreq.valid    = 1'b1;
        dreq.strobe   = 8'h0F;
        mresp.addr_ok = 1'b1;
        settle("iso.t1");
        check_eq("iso.dresp_zero", 256'(dresp), 256'(0));
        check_eq("iso.i_addr_ok", 256'(iresp.addr_ok), 256'(1));
        advance();
        mresp.addr_ok = 1'b0;
        settle("iso.t2");
        check_eq("iso.i_addr_ok_low", 256'(iresp.addr_ok), 256'(0));
        advance();

        // Spurious data_ok while idle.
        do_reset();
        mresp.data_ok = 1'b1;
        mresp.data    = 64'h5555_AAAA_5555_AAAA;
        settle("spur.t0");
        check_eq("spur.iresp_zero", 256'(iresp), 256'(0));
        check_eq("spur.dresp_zero", 256'(dresp), 256'(0));
        advance();
        mresp = '0;
        settle("spur.t1");
        check_eq("spur.idle", 256'(mreq.valid), 256'(0));
        advance();

        // Reset in the middle of a data grant.
        do_reset();
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_0000_3000;
        dreq.size   = 3'd3;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h0123_4567_89AB_CDEF;
        settle("mid.t0");
        advance();
        settle("mid.t1");
        check_eq("mid.t1.mvalid", 256'(mreq.valid), 256'(1));
        advance();
        reset = 1'b1;
        settle("mid.t2");
        check_eq("mid.t2.d_ok", 256'(dresp.data_ok), 256'(0));
        advance();
        reset         = 1'b0;
        mresp.data_ok = 1'b1;
        settle("mid.t3");
        check_eq("mid.t3.mvalid", 256'(mreq.valid), 256'(0));
        check_eq("mid.t3.d_ok", 256'(dresp.data_ok), 256'(0));
        advance();
        mresp.data_ok = 1'b0;
        settle("mid.t4");
        check_eq("mid.t4.regrant", 256'(mreq.valid), 256'(1));
        advance();

        // Starvation bound: both sides request continuously, memory answers at once.
        do_reset();
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h0000_0000_0000_0100;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_0000_0200;
        dreq.size   = 3'd3;
        dreq.strobe = 8'hFF;
        prev_vld    = 1'b0;
        for (int c = 0; c < 60 && grants.size() < 10; c++) begin
            mresp.data_ok = mreq.valid;
            settle("starve");
            if (mreq.valid && !prev_vld) grants.push_back(mreq.is_write ? 2 : 1);
            prev_vld = mreq.valid;
            advance();
        end
        mresp = '0;
        check_eq("starve.count", 256'(grants.size()), 256'(10));
        for (int k = 0; k < grants.size(); k++) begin
            check_eq($sformatf("starve.grant%0d", k), 256'(grants[k]), 256'((k % 5 == 4) ? 1 : 2));
        end

        // Randomized traffic against the ownership model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!ireq.valid && $urandom_range(0, 2) == 0) begin
                ireq.valid = 1'b1;
                ireq.addr  = {$urandom, $urandom};
            end
            if (!dreq.valid && $urandom_range(0, 2) == 0) begin
                dreq.valid  = 1'b1;
                dreq.addr   = {$urandom, $urandom};
                dreq.size   = 3'($urandom_range(0, 3));
                dreq.strobe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                dreq.data   = {$urandom, $urandom};
            end
            mresp.addr_ok = 1'($urandom_range(0, 1));
            mresp.data    = {$urandom, $urandom};
            mresp.data_ok = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            reset         = ($urandom_range(0, 99) == 0);
            settle("rnd");
            i_done = exp_iresp.data_ok;
            d_done = exp_dresp.data_ok;
            advance();
            if (i_done) ireq.valid = 1'b0;
            if (d_done) dreq.valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
